// File: rtl/packmem_pkg.sv
// Shared definitions for the packet-memory access arbiters: requester ids,
// the read tag carried alongside each issued read, and the read-latency calc.
package packmem_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_FWD = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
    logic    hit;
  } rd_tag_t;

  // One cycle of array access plus any register stages around it.
  function automatic int unsigned memlat_calc(input int unsigned buf_in,
                                              input int unsigned buf_out);
    return 1 + buf_in + buf_out;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. Combinational grants; last_gnt remembers the
// most recent winner so the other requester wins the next conflict.
module rr_arb2
  import packmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  req_id_t last_gnt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = (last_gnt == REQ_FWD);
        gnt1 = (last_gnt == REQ_CPU);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt <= REQ_FWD;
    end else if (gnt0) begin
      last_gnt <= REQ_CPU;
    end else if (gnt1) begin
      last_gnt <= REQ_FWD;
    end
  end

endmodule

// File: rtl/packmem_rd_arbiter.sv
// Packet-memory read-port arbiter: round-robin grant, MEMLAT-deep tag pipe
// routing returns to their issuer. PACKMEM_RDARB_CACHE_EN adds a one-word cache.
module packmem_rd_arbiter
  import packmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BUF_IN     = 0,
  parameter int unsigned BUF_OUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_rd_en,
  output logic                  req0_gnt,
  output logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_vld,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_rd_en,
  output logic                  req1_gnt,
  output logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_vld,
  input  logic                  inval,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_vld,
  output logic                  err
);

  localparam int unsigned MEMLAT = memlat_calc(BUF_IN, BUF_OUT);

  logic                  out_en;
  logic                  active;
  logic                  any_gnt;
  logic                  hit;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] cache_data;
  logic [DATA_WIDTH-1:0] ret_data;
  rd_tag_t               new_tag;
  rd_tag_t               head;
  rd_tag_t               pipe [MEMLAT];

  // Outputs stay quiet during reset and for the first cycle after it.
  always_ff @(posedge clk) begin
    out_en <= rst;
  end
  assign active = rst & out_en;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (active),
    .req0 (req0_rd_en),
    .req1 (req1_rd_en),
    .gnt0 (req0_gnt),
    .gnt1 (req1_gnt)
  );

  assign any_gnt  = req0_gnt | req1_gnt;
  assign win_addr = req1_gnt ? req1_addr : req0_addr;

`ifdef PACKMEM_RDARB_CACHE_EN
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic                  pend_v;

  assign hit = any_gnt && pend_v && !inval && (win_addr == pend_addr);

  // A miss issued in the same cycle as inval reads the new buffer, so it is cacheable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_v <= 1'b0;
    end else if (any_gnt && !hit) begin
      pend_v    <= 1'b1;
      pend_addr <= win_addr;
    end else if (inval) begin
      pend_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (head.v && !head.hit) begin
      cache_data <= mem_data;
    end
  end
`else
  logic unused_inval;
  assign unused_inval = inval;
  assign hit          = 1'b0;
  assign cache_data   = '0;
`endif

  assign new_tag = '{v: any_gnt, id: (req1_gnt ? REQ_FWD : REQ_CPU), hit: hit};

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEMLAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= new_tag;
      for (int unsigned i = 1; i < MEMLAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign head = pipe[MEMLAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (mem_vld && !head.v) begin
      err_q <= 1'b1;
    end
  end

  always_comb begin
    mem_rd_en = any_gnt & ~hit;
    mem_addr  = mem_rd_en ? win_addr : '0;
    ret_data  = head.hit ? cache_data : mem_data;
    req0_vld  = active && head.v && (head.id == REQ_CPU);
    req1_vld  = active && head.v && (head.id == REQ_FWD);
    req0_data = active ? ret_data : '0;
    req1_data = active ? ret_data : '0;
    err       = active & err_q;
  end

endmodule

// File: tb/tb_packmem_rd_arbiter.sv
// Scoreboard bench for packmem_rd_arbiter: randomized requests, a latency-line
// memory model, and a grant/return reference computed from the arbitration rules.
module tb_packmem_rd_arbiter;

  localparam int AW     = 9;
  localparam int DW     = 64;
  localparam int BUF_IN = 1;
  localparam int BUF_OUT = 1;
  localparam int MEMLAT = 1 + BUF_IN + BUF_OUT;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          req0_rd_en = 1'b0, req1_rd_en = 1'b0;
  logic          req0_gnt, req1_gnt, req0_vld, req1_vld;
  logic [DW-1:0] req0_data, req1_data;
  logic          inval = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_data;
  logic          mem_vld;
  logic          err;

  logic spur = 1'b0, drop = 1'b0;
  int   cyc = 0;
  logic rst_prev = 1'b0;
  int   vectors = 0, miscompares = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  bit   due[int];

  packmem_rd_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BUF_IN     (BUF_IN),
    .BUF_OUT    (BUF_OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_addr  (req0_addr),
    .req0_rd_en (req0_rd_en),
    .req0_gnt   (req0_gnt),
    .req0_data  (req0_data),
    .req0_vld   (req0_vld),
    .req1_addr  (req1_addr),
    .req1_rd_en (req1_rd_en),
    .req1_gnt   (req1_gnt),
    .req1_data  (req1_data),
    .req1_vld   (req1_vld),
    .inval      (inval),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_data   (mem_data),
    .mem_vld    (mem_vld),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  // Ping-pong buffer content: the word depends on which bank is live.
  function automatic logic [DW-1:0] word(input logic bank, input logic [AW-1:0] a);
    return {16'hC0DE, 7'd0, a, 15'd0, bank, 7'd0, ~a};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(3) == 0) return AW'($urandom);
    return AW'($urandom_range(5));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: reads return MEMLAT cycles later; inval swaps banks.
  logic              bank = 1'b0;
  logic [MEMLAT-1:0] ml_v = '0;
  logic [DW-1:0]     ml_d [MEMLAT];

  always @(posedge clk) begin
    if (!rst) begin
      ml_v <= '0;
    end else begin
      for (int i = MEMLAT - 1; i > 0; i--) begin
        ml_v[i] <= ml_v[i-1];
        ml_d[i] <= ml_d[i-1];
      end
      ml_v[0] <= mem_rd_en;
      ml_d[0] <= word(bank ^ inval, mem_addr);
    end
    bank <= bank ^ inval;
  end

  assign mem_vld  = (ml_v[MEMLAT-1] & ~drop) | spur;
  assign mem_data = ml_v[MEMLAT-1] ? ml_d[MEMLAT-1] : 64'hBAD0_BAD0_BAD0_BAD0;

  // Reference model on the issue side: grant rules, cache hit rule, err rule.
  logic          last_m = 1'b1;
  logic          err_exp = 1'b0;
`ifdef PACKMEM_RDARB_CACHE_EN
  logic          pend_v_m = 1'b0;
  logic [AW-1:0] pend_a_m = '0;
`endif

  always @(negedge clk) begin
    logic          blocked, e0, e1, hit_m;
    logic [AW-1:0] a;
    blocked = !rst || !rst_prev;
    e0 = !blocked && req0_rd_en && (!req1_rd_en || last_m);
    e1 = !blocked && req1_rd_en && (!req0_rd_en || !last_m);
    chk("gnt0", req0_gnt, e0);
    chk("gnt1", req1_gnt, e1);
    chk("err", err, !blocked && err_exp);
    hit_m = 1'b0;
    if (e0 || e1) begin
      a = e1 ? req1_addr : req0_addr;
`ifdef PACKMEM_RDARB_CACHE_EN
      hit_m = pend_v_m && (a == pend_a_m) && !inval;
      if (!hit_m) begin
        pend_v_m = 1'b1;
        pend_a_m = a;
      end
`endif
      chk("mem_rd_en", mem_rd_en, !hit_m);
      if (!hit_m) chk("mem_addr", mem_addr, a);
      if (e1) q1.push_back('{d: word(bank ^ inval, a), due: cyc + MEMLAT});
      else    q0.push_back('{d: word(bank ^ inval, a), due: cyc + MEMLAT});
      due[cyc + MEMLAT] = 1'b1;
      last_m = e1;
    end else begin
      chk("mem_rd_en_idle", mem_rd_en, 1'b0);
`ifdef PACKMEM_RDARB_CACHE_EN
      if (inval) pend_v_m = 1'b0;
`endif
    end
    if (!rst) begin
      q0.delete();
      q1.delete();
      due.delete();
      last_m  = 1'b1;
      err_exp = 1'b0;
`ifdef PACKMEM_RDARB_CACHE_EN
      pend_v_m = 1'b0;
`endif
    end else if (mem_vld && !due.exists(cyc)) begin
      err_exp = 1'b1;
    end
  end

  // Return monitor: pops the scoreboard whenever a return is due or presented.
  always @(negedge clk) begin
    exp_t e;
    logic x0, x1;
    if (!rst || !rst_prev) begin
      chk("vld0_rst", req0_vld, 1'b0);
      chk("vld1_rst", req1_vld, 1'b0);
      chk("data0_rst", req0_data, '0);
    end else begin
      x0 = (q0.size() > 0) && (q0[0].due == cyc);
      x1 = (q1.size() > 0) && (q1[0].due == cyc);
      chk("vld0", req0_vld, x0);
      chk("vld1", req1_vld, x1);
      if (x0) begin
        e = q0.pop_front();
        if (req0_vld) begin
          chk("data0", req0_data, e.d);
          chk("data0_bcast", req1_data, e.d);
        end
      end
      if (x1) begin
        e = q1.pop_front();
        if (req1_vld) begin
          chk("data1", req1_data, e.d);
          chk("data1_bcast", req0_data, e.d);
        end
      end
    end
  end

  logic took0 = 1'b0, took1 = 1'b0;

  task automatic step();
    @(negedge clk);
    #1;
    took0 = req0_gnt;
    took1 = req1_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    int quiet;
    quiet = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // Single requester, consecutive addresses
    req0_rd_en = 1'b1; req0_addr = 9'd5; step();
    req0_addr = 9'd6; step();
    req0_rd_en = 1'b0;
    repeat (MEMLAT + 1) step();

    // Both requesting: grants alternate
    req0_rd_en = 1'b1; req0_addr = 9'd20;
    req1_rd_en = 1'b1; req1_addr = 9'd30;
    repeat (4) begin
      step();
      if (took0) req0_addr = req0_addr + 9'd1;
      if (took1) req1_addr = req1_addr + 9'd1;
    end
    req0_rd_en = 1'b0; req1_rd_en = 1'b0;
    repeat (MEMLAT + 1) step();

    // Miss, hit, bank swap, miss again
    req0_rd_en = 1'b1; req0_addr = 9'd9; step();
    req0_rd_en = 1'b0; req1_rd_en = 1'b1; req1_addr = 9'd9; step();
    req1_rd_en = 1'b0; inval = 1'b1; step();
    inval = 1'b0; req0_rd_en = 1'b1; req0_addr = 9'd9; step();
    req0_rd_en = 1'b0;
    repeat (MEMLAT + 1) step();

    // Random traffic with a reset while reads are in flight
    for (int n = 0; n < 400; n++) begin
      if (!req0_rd_en || took0) begin
        req0_rd_en = ($urandom_range(9) < 6);
        req0_addr  = rand_addr();
      end
      if (!req1_rd_en || took1) begin
        req1_rd_en = ($urandom_range(9) < 6);
        req1_addr  = rand_addr();
      end
      inval = ($urandom_range(9) == 0);
      drop  = due.exists(cyc) && ($urandom_range(5) == 0);
      spur  = !due.exists(cyc) && (quiet == 0) && ($urandom_range(39) == 0);
      if (n >= 200 && n <= 206) begin
        spur = 1'b0;
        drop = 1'b0;
        req0_rd_en = 1'b1;
        req1_rd_en = (n != 202);
      end
      if (n == 203) rst = 1'b0;
      if (n == 204) begin
        rst   = 1'b1;
        quiet = 3;
      end
      step();
      if (quiet > 0) quiet--;
    end
    req0_rd_en = 1'b0; req1_rd_en = 1'b0;
    inval = 1'b0; spur = 1'b0; drop = 1'b0;
    repeat (MEMLAT + 3) step();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    // Spurious return: err sticks until reset
    pulse_reset();
    step();
    repeat (MEMLAT + 1) step();
    spur = 1'b1; step();
    spur = 1'b0;
    repeat (5) step();
    pulse_reset();
    repeat (3) step();
    chk("q0_final", q0.size(), 0);
    chk("q1_final", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
